// File: rtl/ram_bus_pipe.sv
// Single-port word RAM behind a pipelined bus slave: byte-lane writes, read-first data,
// fixed request-to-ack latency, optional zero-fill after reset.
module ram_bus_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1024,
    parameter int LATENCY        = 1,
    parameter     INIT_FILE      = "",
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cyc,
    input  logic                stb,
    input  logic                we,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_m2s,
    output logic [DATA_W-1:0]   data_s2m,
    output logic                ack,
    output logic                err,
    output logic                stall
);
    localparam int NB = DATA_W / 8;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                           r_state;
    logic [ADDR_W-1:0]                r_cnt;
    logic [DATA_W-1:0]                r_mem [DEPTH];
    logic [LATENCY-1:0]               r_vld_pipe;
    logic [LATENCY-1:0]               r_err_pipe;
    logic [LATENCY-1:0][DATA_W-1:0]   r_dat_pipe;

    logic          w_acc;
    logic          w_inr;
    logic          w_vo;
    logic [MW-1:0] w_idx;
    logic [MW-1:0] w_cidx;

    assign stall  = (r_state == S_INIT);
    assign w_acc  = cyc & stb & ~stall & ~rst;
    assign w_inr  = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    assign w_idx  = addr[MW-1:0];
    assign w_cidx = r_cnt[MW-1:0];

    // Array read register samples before the write lands, giving read-first data.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[w_cidx] <= '0;
        end else if (w_acc && w_inr && we) begin
            for (int b = 0; b < NB; b++)
                if (sel[b]) r_mem[w_idx][b*8 +: 8] <= data_m2s[b*8 +: 8];
        end
        r_dat_pipe[0] <= r_mem[w_idx];
        for (int i = 1; i < LATENCY; i++)
            r_dat_pipe[i] <= r_dat_pipe[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? S_INIT : S_READY;
            r_cnt      <= '0;
            r_vld_pipe <= '0;
            r_err_pipe <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_READY;
                end
                default: r_state <= S_READY;
            endcase
            // Dropping cyc abandons everything in flight.
            if (!cyc) begin
                r_vld_pipe <= '0;
                r_err_pipe <= '0;
            end else begin
                r_vld_pipe[0] <= w_acc;
                r_err_pipe[0] <= w_acc & ~w_inr;
                for (int i = 1; i < LATENCY; i++) begin
                    r_vld_pipe[i] <= r_vld_pipe[i-1];
                    r_err_pipe[i] <= r_err_pipe[i-1];
                end
            end
        end
    end

    assign w_vo     = r_vld_pipe[LATENCY-1] & cyc;
    assign ack      = w_vo & ~r_err_pipe[LATENCY-1];
    assign err      = w_vo &  r_err_pipe[LATENCY-1];
    assign data_s2m = ack ? r_dat_pipe[LATENCY-1] : '0;

endmodule

// File: tb/tb_ram_bus_pipe.sv
// Bench for ram_bus_pipe: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a queue/array reference model.
module tb_ram_bus_pipe;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
    localparam int LAT   = 3;

    typedef struct {
        logic          rst, cyc, stb, we;
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          e_ack, e_err;
        logic [DW-1:0] e_dat;
    } vec_t;

    typedef struct {
        int            due;
        bit            err;
        logic [DW-1:0] dat;
    } pend_t;

    logic          clk = 1'b0;
    logic          rst, cyc, stb, we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat, rdat;
    logic          ack, err, stall;

    ram_bus_pipe #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT),
        .INIT_FILE(""), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .sel(sel),
        .addr(addr), .data_m2s(wdat), .data_s2m(rdat),
        .ack(ack), .err(err), .stall(stall)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_err = 0;
    int            t = 0;
    int            init_end = 0;
    bit            chk_en = 0;
    pend_t         pq[$];
    logic [DW-1:0] m_mem [DEPTH];
    logic          s_ack, s_err, s_stall;
    logic [DW-1:0] s_dat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d actual=0x%h required=0x%h", nm, t, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit c, input bit s, input bit w,
                                input logic [3:0] se, input int a, input logic [31:0] d);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.sel = se;
        v.addr = AW'(a); v.wd = d;
        v.e_ack = 1'b0; v.e_err = 1'b0; v.e_dat = '0;
        return v;
    endfunction

    // Drives one cycle at the negative edge, checks this cycle's outputs, advances the model.
    task automatic step(input vec_t v);
        logic          e_ack, e_err, e_stall;
        logic [DW-1:0] e_dat;
        pend_t         p;
        bit            acc;
        rst = v.rst; cyc = v.cyc; stb = v.stb; we = v.we;
        sel = v.sel; addr = v.addr; wdat = v.wd;
        #1;
        s_ack = ack; s_err = err; s_dat = rdat; s_stall = stall;
        e_ack = 1'b0; e_err = 1'b0; e_dat = '0;
        e_stall = (t <= init_end);
        if (pq.size() > 0 && pq[0].due == t) begin
            if (v.cyc) begin
                e_ack = !pq[0].err;
                e_err = pq[0].err;
                e_dat = pq[0].err ? '0 : pq[0].dat;
            end
            void'(pq.pop_front());
        end
        if (!v.cyc) pq.delete();
        if (chk_en) begin
            chk("ack",   32'(s_ack),   32'(e_ack));
            chk("err",   32'(s_err),   32'(e_err));
            chk("data",  s_dat,        e_dat);
            chk("stall", 32'(s_stall), 32'(e_stall));
        end
        acc = v.cyc && v.stb && !e_stall && !v.rst;
        if (acc) begin
            p.due = t + LAT;
            p.err = (int'(v.addr) >= DEPTH);
            p.dat = p.err ? '0 : m_mem[int'(v.addr)];
            pq.push_back(p);
            if (!p.err && v.we)
                for (int b = 0; b < 4; b++)
                    if (v.sel[b]) m_mem[int'(v.addr)][b*8 +: 8] = v.wd[b*8 +: 8];
        end
        if (v.rst) begin
            pq.delete();
            init_end = t + DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            chk_en = 1;
        end
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    vec_t tbl [9];
    int   n_stall;
    bit   done;
    logic rec_ack [7];
    logic [DW-1:0] rec_dat [7];
    int   n_resp;

    initial begin
        // Rows: rst cyc stb we sel addr wd | ack err data (three cycles after the request)
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 10'd5,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'd5,   32'h0,        1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 10'd5,   32'h000000AA, 1'b0, 1'b0, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'd5,   32'h0,        1'b1, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'd1000, 32'h0,       1'b1, 1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 10'd999, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 1'b0, 32'hDEADBEAA};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd0,   32'h0,        1'b0, 1'b1, 32'h0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 1'b0, 32'h0};

        // Reset, partial clear with requests ignored, then a restarting reset pulse.
        step(mk(1, 0, 0, 0, 4'h0, 0, 0));
        for (int i = 0; i < 5; i++) step(mk(0, 1, 1, 0, 4'hF, i, 0));
        step(mk(1, 0, 0, 0, 4'h0, 0, 0));
        n_stall = 0;
        done = 0;
        for (int i = 0; i < 2 * DEPTH && !done; i++) begin
            step(mk(0, 1, 1, 0, 4'hF, $urandom_range(0, 15), $urandom));
            if (s_stall) n_stall++;
            else done = 1;
        end
        chk("stall_len", 32'(n_stall), 32'(DEPTH));
        for (int i = 0; i < LAT; i++) step(mk(0, 1, 0, 0, 4'h0, 0, 0));
        for (int i = 0; i < 16; i++) step(mk(0, 1, 1, 0, 4'hF, i, 0));
        for (int i = 0; i < LAT + 1; i++) step(mk(0, 1, 0, 0, 4'h0, 0, 0));

        for (int i = 0; i < 9; i++) begin
            step(tbl[i]);
            chk("tbl_ack",  32'(s_ack), 32'(tbl[i].e_ack));
            chk("tbl_err",  32'(s_err), 32'(tbl[i].e_err));
            chk("tbl_data", s_dat,      tbl[i].e_dat);
        end

        // Back-to-back reads of preloaded words: acks on consecutive cycles, in order.
        for (int i = 0; i < 4; i++) step(mk(0, 1, 1, 1, 4'hF, i, 32'h10 + 32'(i)));
        for (int i = 0; i < LAT; i++) step(mk(0, 1, 0, 0, 4'h0, 0, 0));
        for (int j = 0; j < 7; j++) begin
            if (j < 4) step(mk(0, 1, 1, 0, 4'hF, j, 0));
            else       step(mk(0, 1, 0, 0, 4'h0, 0, 0));
            rec_ack[j] = s_ack;
            rec_dat[j] = s_dat;
        end
        for (int j = 0; j < 7; j++) begin
            chk("b2b_ack", 32'(rec_ack[j]), (j >= LAT) ? 32'd1 : 32'd0);
            if (j >= LAT) chk("b2b_data", rec_dat[j], 32'h10 + 32'(j - LAT));
        end

        // Two reads in flight, then cyc drops: neither may ever complete.
        n_resp = 0;
        step(mk(0, 1, 1, 0, 4'hF, 0, 0));
        n_resp += int'(s_ack) + int'(s_err);
        step(mk(0, 1, 1, 0, 4'hF, 1000, 0));
        n_resp += int'(s_ack) + int'(s_err);
        step(mk(0, 0, 0, 0, 4'h0, 0, 0));
        n_resp += int'(s_ack) + int'(s_err);
        for (int i = 0; i < LAT + 3; i++) begin
            step(mk(0, 1, 0, 0, 4'h0, 0, 0));
            n_resp += int'(s_ack) + int'(s_err);
        end
        chk("flush_resp", 32'(n_resp), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            vec_t v;
            int   a;
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(995, 1023))
                                            : int'($urandom_range(0, 15));
            v = mk(0, ($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
                   $urandom_range(0, 1), 4'($urandom_range(0, 15)), a, $urandom);
            if ($urandom_range(0, 1499) == 0) v = mk(1, 0, 0, 0, 4'h0, 0, 0);
            step(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
